flash_reader_fsm: RTL and testbench

FLASH_READER_FSM -- requirements
Module: flash_reader_fsm

---
 rtl/flash_reader_fsm_pkg.sv | 16 +
 rtl/flash_addr_counter.sv | 39 +++
 rtl/flash_reader_fsm.sv | 155 +++++++++++++++
 tb/tb_flash_reader_fsm.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_reader_fsm_pkg.sv
// Shared constants and state encoding for the flash sample reader.
// The default song spans flash word addresses 0 .. ADDR_MAX.
package flash_reader_fsm_pkg;

    localparam int unsigned ADDR_W = 23;
    localparam logic [ADDR_W-1:0] ADDR_MAX = 23'h7FFFF;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_SAMPLE1   = 3'd3,
        S_SAMPLE2   = 3'd4
    } state_t;

endpackage

// File: rtl/flash_addr_counter.sv
// Up/down song word-address counter with wrap at both ends and a load port.
// Load has priority over step.
module flash_addr_counter #(
    parameter int unsigned       ADDR_W   = flash_reader_fsm_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(flash_reader_fsm_pkg::ADDR_MAX)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              step,
    input  logic              up,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        addr_d = addr;
        if (load) begin
            addr_d = load_value;
        end else if (step) begin
            if (up) begin
                addr_d = (addr == ADDR_MAX) ? '0 : addr + ADDR_W'(1);
            end else begin
                addr_d = (addr == '0) ? ADDR_MAX : addr - ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr <= '0;
        end else begin
            addr <= addr_d;
        end
    end

endmodule

// File: rtl/flash_reader_fsm.sv
// Streams 8-bit audio samples from a 32-bit Avalon-style flash port,
// two samples per word, forward or backward, paced by sample_tick.
module flash_reader_fsm #(
    parameter int unsigned       ADDR_W   = flash_reader_fsm_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(flash_reader_fsm_pkg::ADDR_MAX)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_reading,
    input  logic              direction,
    input  logic              restart,
    input  logic              sample_tick,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    input  logic              flash_mem_waitrequest,
    input  logic [31:0]       flash_mem_readdata,
    input  logic              flash_mem_readdatavalid,
    output logic [7:0]        audio_data,
    output logic              audio_valid
);

    import flash_reader_fsm_pkg::*;

    state_t            state_q, state_d;
    logic              dir_q, dir_d;
    logic [31:0]       word_q, word_d;
    logic              pend_q, pend_d;
    logic              read_d;
    logic [7:0]        audio_data_d;
    logic              audio_valid_d;

    logic              cnt_step, cnt_load;
    logic [ADDR_W-1:0] cnt_load_value;
    logic [ADDR_W-1:0] addr;

    logic              accept_c;
    logic              restart_any_c;
    logic [7:0]        first_c, second_c;

    // Ticks only count while playing; pause freezes everything.
    assign accept_c      = sample_tick & start_reading;
    assign restart_any_c = pend_q | restart;
    assign first_c       = dir_q ? word_q[15:8]  : word_q[31:24];
    assign second_c      = dir_q ? word_q[31:24] : word_q[15:8];

    flash_addr_counter #(
        .ADDR_W   (ADDR_W),
        .ADDR_MAX (ADDR_MAX)
    ) u_addr_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .step       (cnt_step),
        .up         (dir_q),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .addr       (addr)
    );

    assign flash_mem_address = addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            dir_q          <= 1'b1;
            word_q         <= '0;
            pend_q         <= 1'b0;
            flash_mem_read <= 1'b0;
            audio_data     <= '0;
            audio_valid    <= 1'b0;
        end else begin
            state_q        <= state_d;
            dir_q          <= dir_d;
            word_q         <= word_d;
            pend_q         <= pend_d;
            flash_mem_read <= read_d;
            audio_data     <= audio_data_d;
            audio_valid    <= audio_valid_d;
        end
    end

    // Next state, address control and restart bookkeeping.
    always_comb begin
        state_d        = state_q;
        dir_d          = dir_q;
        word_d         = word_q;
        pend_d         = restart_any_c;
        cnt_step       = 1'b0;
        cnt_load       = 1'b0;
        cnt_load_value = direction ? '0 : ADDR_MAX;

        case (state_q)
            S_IDLE: begin
                if (restart_any_c) begin
                    cnt_load = 1'b1;
                    pend_d   = 1'b0;
                end
                if (start_reading) begin
                    state_d = S_REQ;
                    dir_d   = direction;
                end
            end
            S_REQ: begin
                if (!flash_mem_waitrequest) begin
                    state_d = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (flash_mem_readdatavalid) begin
                    word_d  = flash_mem_readdata;
                    state_d = S_SAMPLE1;
                end
            end
            S_SAMPLE1: begin
                if (accept_c) begin
                    state_d = S_SAMPLE2;
                end
            end
            S_SAMPLE2: begin
                if (accept_c) begin
                    // A pending restart replaces the normal step.
                    if (restart_any_c) begin
                        cnt_load = 1'b1;
                        pend_d   = 1'b0;
                    end else begin
                        cnt_step = 1'b1;
                    end
                    if (start_reading) begin
                        state_d = S_REQ;
                        dir_d   = direction;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered output values.
    always_comb begin
        read_d        = (state_d == S_REQ);
        audio_data_d  = audio_data;
        audio_valid_d = 1'b0;
        if (accept_c && (state_q == S_SAMPLE1)) begin
            audio_data_d  = first_c;
            audio_valid_d = 1'b1;
        end else if (accept_c && (state_q == S_SAMPLE2)) begin
            audio_data_d  = second_c;
            audio_valid_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_flash_reader_fsm.sv
// Scoreboard bench for flash_reader_fsm: expected samples and read addresses
// are queued by the stimulus and checked by independent monitors.
module tb_flash_reader_fsm;

    logic        clk;
    logic        reset_n;
    logic        start_reading;
    logic        direction;
    logic        restart;
    logic        sample_tick;
    logic        flash_mem_read;
    logic [22:0] flash_mem_address;
    logic        flash_mem_waitrequest;
    logic [31:0] flash_mem_readdata;
    logic        flash_mem_readdatavalid;
    logic [7:0]  audio_data;
    logic        audio_valid;

    int total = 0;
    int bad = 0;
    int valid_cnt = 0;
    logic auto_resp = 1'b1;
    logic [22:0] resp_addr;

    logic [7:0]  exp_audio[$];
    logic [22:0] exp_addr[$];

    flash_reader_fsm dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .start_reading           (start_reading),
        .direction               (direction),
        .restart                 (restart),
        .sample_tick             (sample_tick),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdata      (flash_mem_readdata),
        .flash_mem_readdatavalid (flash_mem_readdatavalid),
        .audio_data              (audio_data),
        .audio_valid             (audio_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [22:0] a);
        case (a)
            23'h0:     return 32'hAABBCCDD;
            23'h1:     return 32'h55667788;
            23'h2:     return 32'h01020304;
            23'h100:   return 32'hDEADBEEF;
            23'h7FFFF: return 32'h11223344;
            23'h7FFFE: return 32'h99887766;
            default:   return {a[7:0], 8'h3C, ~a[7:0], 8'hC3};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input logic d);
        if (d) begin
            exp_audio.push_back(w[15:8]);
            exp_audio.push_back(w[31:24]);
        end else begin
            exp_audio.push_back(w[31:24]);
            exp_audio.push_back(w[15:8]);
        end
    endtask

    // Pulse sample_tick until one audio_valid pulse appears (bounded).
    task automatic tick_valid();
        int v0 = valid_cnt;
        int n = 0;
        while (valid_cnt == v0 && n < 40) begin
            @(posedge clk); #1 sample_tick = 1'b1;
            @(posedge clk); #1 sample_tick = 1'b0;
            repeat (2) @(posedge clk);
            n++;
        end
        if (valid_cnt == v0) begin
            total++;
            bad++;
            $display("FAIL tick_timeout: got no audio_valid after %0d ticks", n);
        end
    endtask

    task automatic pulse_tick();
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // Audio monitor.
    always @(negedge clk) begin
        if (audio_valid) begin
            valid_cnt++;
            total++;
            if (exp_audio.size() == 0) begin
                bad++;
                $display("FAIL audio_unexpected: got %0h expected none", audio_data);
            end else begin
                logic [7:0] e;
                e = exp_audio.pop_front();
                if (audio_data !== e) begin
                    bad++;
                    $display("FAIL audio_sample: got %0h expected %0h", audio_data, e);
                end
            end
        end
    end

    // Read-address monitor: one compare per accepted read.
    always @(negedge clk) begin
        if (reset_n && flash_mem_read && !flash_mem_waitrequest) begin
            total++;
            if (exp_addr.size() == 0) begin
                bad++;
                $display("FAIL read_unexpected: got addr %0h expected none", flash_mem_address);
            end else begin
                logic [22:0] e;
                e = exp_addr.pop_front();
                if (flash_mem_address !== e) begin
                    bad++;
                    $display("FAIL read_addr: got %0h expected %0h", flash_mem_address, e);
                end
            end
        end
    end

    // Flash slave model: fixed read latency after acceptance.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_resp && reset_n && flash_mem_read && !flash_mem_waitrequest) begin
                resp_addr = flash_mem_address;
                @(posedge clk); #1;
                @(posedge clk); #1;
                flash_mem_readdata      = mem_word(resp_addr);
                flash_mem_readdatavalid = 1'b1;
                @(posedge clk); #1;
                flash_mem_readdatavalid = 1'b0;
            end
        end
    end

    initial begin
        int v0;
        int n;
        reset_n                 = 1'b0;
        start_reading           = 1'b0;
        direction               = 1'b1;
        restart                 = 1'b0;
        sample_tick             = 1'b0;
        flash_mem_waitrequest   = 1'b0;
        flash_mem_readdata      = '0;
        flash_mem_readdatavalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_read", 32'(flash_mem_read), 32'h0);
        check("rst_addr", 32'(flash_mem_address), 32'h0);
        check("rst_audio", 32'(audio_data), 32'h0);
        check("rst_valid", 32'(audio_valid), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Forward from 0.
        exp_addr.push_back(23'h0);
        exp_addr.push_back(23'h1);
        exp_audio.push_back(8'hCC);
        exp_audio.push_back(8'hAA);
        @(posedge clk); #1 start_reading = 1'b1;
        tick_valid();
        tick_valid();

        // Direction change mid-word only applies at next read.
        direction = 1'b0;
        exp_audio.push_back(8'h77);
        exp_audio.push_back(8'h55);
        exp_addr.push_back(23'h2);
        tick_valid();
        tick_valid();
        exp_audio.push_back(8'h01);
        exp_audio.push_back(8'h03);
        exp_addr.push_back(23'h1);
        tick_valid();
        tick_valid();
        exp_audio.push_back(8'h55);
        exp_audio.push_back(8'h77);
        exp_addr.push_back(23'h0);
        tick_valid();
        tick_valid();
        // Backward wrap from 0.
        exp_audio.push_back(8'hAA);
        exp_audio.push_back(8'hCC);
        exp_addr.push_back(23'h7FFFF);
        tick_valid();
        tick_valid();
        exp_audio.push_back(8'h11);
        exp_audio.push_back(8'h33);
        exp_addr.push_back(23'h7FFFE);
        tick_valid();
        flash_mem_waitrequest = 1'b1;
        tick_valid();

        // Stall: request held stable while waitrequest is high.
        n = 0;
        while (!flash_mem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_read", 32'(flash_mem_read), 32'h1);
            check("stall_addr", 32'(flash_mem_address), 32'h7FFFE);
        end
        @(posedge clk); #1 flash_mem_waitrequest = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("read_drop", 32'(flash_mem_read), 32'h0);

        // Pause in SAMPLE2.
        exp_audio.push_back(8'h99);
        exp_audio.push_back(8'h77);
        exp_addr.push_back(23'h7FFFD);
        tick_valid();
        @(posedge clk); #1 start_reading = 1'b0;
        v0 = valid_cnt;
        for (int i = 0; i < 3; i++) pulse_tick();
        check("pause_no_valid", 32'(valid_cnt), 32'(v0));
        check("pause_read", 32'(flash_mem_read), 32'h0);
        check("pause_addr", 32'(flash_mem_address), 32'h7FFFE);
        @(posedge clk); #1 start_reading = 1'b1;
        tick_valid();
        repeat (4) @(posedge clk);
        check("resume_one_pulse", 32'(valid_cnt), 32'(v0 + 1));

        // Restart pulsed during the read applies at the next address update.
        direction = 1'b1;
        @(posedge clk); #1 restart = 1'b1;
        @(posedge clk); #1 restart = 1'b0;
        push_word(mem_word(23'h7FFFD), 1'b0);
        exp_addr.push_back(23'h0);
        tick_valid();
        tick_valid();

        // Walk forward to 0x100.
        for (int a = 0; a < 256; a++) begin
            push_word(mem_word(23'(a)), 1'b1);
            exp_addr.push_back(23'(a + 1));
            tick_valid();
            tick_valid();
        end
        repeat (8) @(posedge clk);
        #1 restart = 1'b1;
        @(posedge clk); #1 restart = 1'b0;
        exp_audio.push_back(8'hBE);
        exp_audio.push_back(8'hDE);
        exp_addr.push_back(23'h0);
        tick_valid();
        tick_valid();

        // Reset while waiting for read data.
        exp_audio.push_back(8'hCC);
        exp_audio.push_back(8'hAA);
        exp_addr.push_back(23'h1);
        tick_valid();
        auto_resp = 1'b0;
        tick_valid();
        n = 0;
        while (exp_addr.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        check("rd_before_rst", 32'(exp_addr.size()), 32'h0);
        @(posedge clk); #2;
        reset_n       = 1'b0;
        start_reading = 1'b0;
        #1;
        check("async_read", 32'(flash_mem_read), 32'h0);
        check("async_addr", 32'(flash_mem_address), 32'h0);
        check("async_audio", 32'(audio_data), 32'h0);
        check("async_valid", 32'(audio_valid), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        v0 = valid_cnt;
        @(posedge clk); #1;
        flash_mem_readdata      = 32'hAABBCCDD;
        flash_mem_readdatavalid = 1'b1;
        @(posedge clk); #1 flash_mem_readdatavalid = 1'b0;
        for (int i = 0; i < 3; i++) pulse_tick();
        check("late_rdv_no_valid", 32'(valid_cnt), 32'(v0));
        check("late_rdv_read", 32'(flash_mem_read), 32'h0);
        check("audio_q_empty", 32'(exp_audio.size()), 32'h0);
        check("addr_q_empty", 32'(exp_addr.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
